led_strip_serializer: RTL and testbench



---
 rtl/led_strip_serializer.sv | 109 ++++++++++
 tb/tb_led_strip_serializer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_strip_serializer.sv
// led_strip_serializer: one shared bit engine that clocks APA102-class frames
// (start frame, one word per LED, end frame) out of every strip's C/D pin pair in parallel.
module led_strip_serializer #(
    parameter int LANES    = 28,
    parameter int LEDS     = 64,
    parameter int CLK_DIV  = 4,
    parameter int END_BITS = 32 * ((LEDS + 63) / 64)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4:0]            brightness,
    input  logic                  px_valid,
    output logic                  px_ready,
    input  logic [24*LANES-1:0]   px_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic [LANES-1:0]      led_c,
    output logic [LANES-1:0]      led_d
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int LW = $clog2(LEDS + 1);
    localparam int EW = $clog2(END_BITS + 1);

    typedef enum logic [2:0] {IDLE, SOF, LOAD, PIX, EOF} state_t;

    state_t state, next_state;
    logic [DW-1:0] div;
    logic [4:0] bit_cnt;
    logic [LW-1:0] led_cnt;
    logic [EW-1:0] end_cnt;
    logic [4:0] bright;
    logic [31:0] shift [LANES];
    logic [LANES-1:0] shift_next, d_nx;
    logic c, c_nx, ready_nx, busy_nx, done_nx;
    logic serial, hold, ph_end, bit_end, word_end, hs, accept;

    assign serial   = state == SOF || state == PIX || state == EOF;
    assign hold     = next_state == state;
    assign ph_end   = div == DW'(CLK_DIV - 1);
    assign bit_end  = serial && c && ph_end;
    assign word_end = bit_end && bit_cnt == 5'd31;
    assign hs       = state == LOAD && px_valid && px_ready;
    // a start arriving while frame_done is high is the tail of the old frame, not a new request
    assign accept   = state == IDLE && start && !frame_done;
    assign led_c    = {LANES{c}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            c          <= 1'b0;
            led_d      <= '0;
            px_ready   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            div        <= '0;
            bit_cnt    <= '0;
            led_cnt    <= '0;
            end_cnt    <= '0;
            bright     <= '0;
        end else begin
            state      <= next_state;
            c          <= c_nx;
            led_d      <= d_nx;
            px_ready   <= ready_nx;
            busy       <= busy_nx;
            frame_done <= done_nx;
            div        <= serial && hold && !ph_end ? div + DW'(1) : '0;
            bit_cnt    <= state == IDLE ? 5'd0 : (bit_end && state != EOF) ? bit_cnt + 5'd1 : bit_cnt;
            led_cnt    <= state == IDLE ? '0 : (word_end && state == PIX) ? led_cnt + LW'(1) : led_cnt;
            end_cnt    <= state != EOF ? '0 : bit_end ? end_cnt + EW'(1) : end_cnt;
            bright     <= accept ? brightness : bright;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? SOF : IDLE;
            SOF:     next_state = word_end ? LOAD : SOF;
            LOAD:    next_state = hs ? PIX : LOAD;
            PIX:     next_state = !word_end ? PIX : (led_cnt + LW'(1) < LW'(LEDS)) ? LOAD : EOF;
            EOF:     next_state = (bit_end && end_cnt == EW'(END_BITS - 1)) ? IDLE : EOF;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        shift_next = '0;
        for (int i = 0; i < LANES; i++) shift_next[i] = shift[i][30];
    end

    // the LED word header is 3'b111, so its first bit is 1 on every lane
    always_comb begin
        c_nx     = serial && hold ? c ^ ph_end : 1'b0;
        ready_nx = next_state == LOAD;
        busy_nx  = next_state != IDLE;
        done_nx  = state == EOF && next_state == IDLE;
        d_nx     = accept ? '0 : hs ? '1 : (state == PIX && next_state == EOF) ? '1 :
                   (state == PIX && hold && bit_end) ? shift_next : led_d;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (hs) shift[i] <= {3'b111, bright, px_data[24*i +: 8], px_data[24*i+8 +: 8], px_data[24*i+16 +: 8]};
            else if (state == PIX && bit_end) shift[i] <= shift[i] << 1;
        end
    end
endmodule

// File: tb/tb_led_strip_serializer.sv
// tb_led_strip_serializer: table-driven, hand-written and random frames checked against a
// bit-stream model built from pixel words; a second instance covers CLK_DIV=1.
module tb_led_strip_serializer;
    localparam int LANES = 2, LEDS = 2, CLK_DIV = 2, END_BITS = 32;
    localparam int BASE  = (32 + END_BITS) * 2 * CLK_DIV + LEDS * (64 * CLK_DIV + 1);
    localparam int BASE1 = (32 + END_BITS) * 2 * 1 + LEDS * (64 * 1 + 1);

    logic clk = 0, rst = 1, start = 0, start1 = 0, px_valid = 0, valid1 = 1;
    logic [4:0] brightness = 0;
    logic [47:0] px_data = '0, data1 = 48'h00FF00_FF00FF;
    logic px_ready, busy, frame_done, ready1, busy1, done1;
    logic [1:0] led_c, led_d, c1, d1;

    always #5 clk = ~clk;

    led_strip_serializer #(.LANES(LANES), .LEDS(LEDS), .CLK_DIV(CLK_DIV), .END_BITS(END_BITS)) dut (
        .clk(clk), .rst(rst), .start(start), .brightness(brightness), .px_valid(px_valid),
        .px_ready(px_ready), .px_data(px_data), .busy(busy), .frame_done(frame_done),
        .led_c(led_c), .led_d(led_d));

    led_strip_serializer #(.LANES(LANES), .LEDS(LEDS), .CLK_DIV(1), .END_BITS(END_BITS)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .brightness(brightness), .px_valid(valid1),
        .px_ready(ready1), .px_data(data1), .busy(busy1), .frame_done(done1),
        .led_c(c1), .led_d(d1));

    int compared = 0, mismatched = 0;
    int cyc = 0, t_busy = 0, t_done = 0, done_cnt = 0, d_base = 0;
    int hs_idx = 0, stall_idx = -1, stall_left = 0, stall_bad = 0, c_split = 0;
    bit cap0[$], cap1[$];
    logic [47:0] pix_q[$];
    logic [47:0] frame_pix[LEDS];
    logic prev_c = 0, prev_busy = 0;
    logic [1:0] prev_d = 0;

    typedef struct {
        logic [4:0]  b;
        logic [47:0] p0, p1;
        int          sidx, slen, len;
    } vec_t;
    vec_t vecs[3];

    always @(posedge clk) cyc <= cyc + 1;

    // monitor (strip-side capture) followed by the upstream frame-buffer model
    always @(negedge clk) begin
        if (busy === 1'b1 && prev_busy !== 1'b1) t_busy = cyc;
        if (frame_done === 1'b1) begin t_done = cyc; done_cnt++; end
        if (led_c[0] === 1'b1 && prev_c === 1'b0) begin cap0.push_back(led_d[0]); cap1.push_back(led_d[1]); end
        if (led_c[1] !== led_c[0]) c_split++;
        if (px_ready === 1'b1 && (led_c !== 2'b00 || led_d !== prev_d)) stall_bad++;
        prev_c = led_c[0]; prev_d = led_d; prev_busy = busy;
        if (pix_q.size() != 0 && hs_idx == stall_idx && stall_left > 0 && px_ready === 1'b1) begin
            px_valid = 0;
            stall_left--;
        end else begin
            px_valid = pix_q.size() != 0;
            if (pix_q.size() != 0) px_data = pix_q[0];
        end
        if (px_valid && px_ready === 1'b1) begin void'(pix_q.pop_front()); hs_idx++; end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic prep_frame(input logic [4:0] b, input logic [47:0] p0, input logic [47:0] p1,
                              input int sidx, input int slen);
        brightness = b;
        frame_pix[0] = p0; frame_pix[1] = p1;
        pix_q.delete(); pix_q.push_back(p0); pix_q.push_back(p1);
        hs_idx = 0; stall_idx = sidx; stall_left = slen;
        cap0.delete(); cap1.delete();
        stall_bad = 0; c_split = 0; d_base = done_cnt;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
    endtask

    function automatic logic [31:0] cap_word(input int lane, input int pos);
        logic [31:0] w;
        for (int j = 0; j < 32; j++) begin
            if (pos + j < (lane == 0 ? cap0.size() : cap1.size())) w[31-j] = lane == 0 ? cap0[pos+j] : cap1[pos+j];
            else w[31-j] = 1'bx;
        end
        return w;
    endfunction

    // reference: 32 zeros, then {3'b111, brightness, B, G, R} per LED MSB-first, then END_BITS ones
    task automatic check_streams(input string name, input logic [4:0] b);
        bit exp[$], got[$];
        logic [23:0] p;
        logic [31:0] w;
        int bad, n;
        for (int l = 0; l < 2; l++) begin
            exp.delete();
            repeat (32) exp.push_back(1'b0);
            for (int k = 0; k < LEDS; k++) begin
                p = frame_pix[k][24*l +: 24];
                w = {3'b111, b, p[7:0], p[15:8], p[23:16]};
                for (int j = 31; j >= 0; j--) exp.push_back(w[j]);
            end
            repeat (END_BITS) exp.push_back(1'b1);
            if (l == 0) got = cap0; else got = cap1;
            n = got.size() < exp.size() ? got.size() : exp.size();
            bad = -1;
            for (int i = 0; i < n; i++) if (bad < 0 && got[i] != exp[i]) bad = i;
            if (bad < 0 && got.size() != exp.size()) bad = n;
            compared++;
            if (bad >= 0) begin
                mismatched++;
                $display("FAIL %s lane%0d stream: got %0d bits, want %0d bits, first difference at bit %0d",
                         name, l, got.size(), exp.size(), bad);
            end
        end
    endtask

    task automatic finish_frame(input string name, input int exp_len, input logic [4:0] b);
        int n = 0;
        while (done_cnt == d_base && n < 4000) begin @(negedge clk); n++; end
        if (n >= 4000) timeout_fail({name, " frame_done"});
        else begin
            check({name, " length"}, t_done - t_busy, exp_len);
            check_streams(name, b);
            check({name, " handshakes"}, hs_idx, LEDS);
            check({name, " load hold"}, stall_bad, 0);
            check({name, " clock lanes equal"}, c_split, 0);
        end
    endtask

    initial begin
        int n, tog, dbad, rc;
        logic pc;
        logic [31:0] w;
        logic [4:0] rb;
        logic [47:0] r0, r1;
        vecs[0] = '{5'h1F, {24'h0000FF, 24'hFF0000}, {24'h123456, 24'hABCDEF}, -1, 0, 514};
        vecs[1] = '{5'h1F, {24'h0000FF, 24'hFF0000}, {24'h123456, 24'hABCDEF}, 1, 10, 524};
        vecs[2] = '{5'h10, {24'hFFFFFF, 24'h000000}, {24'h00FF00, 24'h5A5AA5}, 0, 1, 515};

        rst = 1; start = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset outputs cycle %0d", i), {led_c, led_d, px_ready, busy, frame_done}, 0);
        end
        rst = 0; start = 0;
        @(negedge clk);
        check("idle after reset", busy, 0);

        for (int i = 0; i < 3; i++) begin
            prep_frame(vecs[i].b, vecs[i].p0, vecs[i].p1, vecs[i].sidx, vecs[i].slen);
            pulse_start();
            finish_frame($sformatf("vec%0d", i), vecs[i].len, vecs[i].b);
            if (i == 0) begin
                check("vec0 lane0 led0 word", cap_word(0, 32), 32'hFF0000FF);
                check("vec0 lane1 led0 word", cap_word(1, 32), 32'hFFFF0000);
            end
        end

        prep_frame(5'h1F, {24'h0000FF, 24'hFF0000}, {24'h00FF00, 24'h00FF00}, -1, 0);
        pulse_start();
        n = 0;
        while (!(hs_idx >= 1 && px_ready === 1'b0) && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) timeout_fail("ignored-start reach PIX");
        repeat (20) @(negedge clk);
        start = 1; brightness = 5'h01;
        @(negedge clk) start = 0;
        finish_frame("ignored start", BASE, 5'h1F);
        w = cap_word(0, 32);
        check("ignored start header", w[31:24], 8'hFF);
        repeat (10) @(negedge clk);
        check("ignored start single done", done_cnt - d_base, 1);
        check("ignored start idle", busy, 0);
        prep_frame(5'h01, {24'h0000FF, 24'hFF0000}, {24'h00FF00, 24'h00FF00}, -1, 0);
        pulse_start();
        finish_frame("next brightness", BASE, 5'h01);
        w = cap_word(0, 32);
        check("next brightness header", w[31:24], 8'hE1);

        prep_frame(5'h1F, {24'h111111, 24'h222222}, {24'h333333, 24'h444444}, -1, 0);
        pulse_start();
        n = 0;
        while (frame_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) timeout_fail("restart frame_done");
        start = 1;
        @(negedge clk);
        check("start on done cycle ignored", busy, 0);
        prep_frame(5'h1F, {24'h0000FF, 24'hFF0000}, {24'h123456, 24'hABCDEF}, -1, 0);
        @(negedge clk) start = 0;
        check("restart next cycle", busy, 1);

        n = 0;
        while (cap0.size() < 43 && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) timeout_fail("reset mid-PIX bit 10");
        rst = 1;
        @(negedge clk);
        check("reset mid-PIX outputs", {led_c, led_d, px_ready, busy, frame_done}, 0);
        rst = 0;
        repeat (60) @(negedge clk);
        check("aborted frame no done", done_cnt - d_base, 0);
        check("aborted frame idle", busy, 0);
        prep_frame(5'h1F, {24'h0000FF, 24'hFF0000}, {24'h123456, 24'hABCDEF}, -1, 0);
        pulse_start();
        finish_frame("after reset", BASE, 5'h1F);

        for (int r = 0; r < 6; r++) begin
            rb = 5'($urandom());
            r0 = 48'({$urandom(), $urandom()});
            r1 = 48'({$urandom(), $urandom()});
            n = $urandom_range(0, 6);
            prep_frame(rb, r0, r1, $urandom_range(0, 1), n);
            pulse_start();
            finish_frame($sformatf("random%0d", r), BASE + n, rb);
        end

        @(negedge clk) start1 = 1;
        @(negedge clk) start1 = 0;
        check("clkdiv1 busy rise", busy1, 1);
        pc = c1[0]; n = 0; tog = 0; dbad = 0; rc = 0;
        while (done1 !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
            if (n <= 40) begin
                if (c1[0] != pc) tog++;
                if (d1 != 2'b00 || c1[1] != c1[0]) dbad++;
            end
            pc = c1[0];
            if (ready1) rc++;
        end
        if (n >= 2000) timeout_fail("clkdiv1 frame_done");
        else check("clkdiv1 length", n, BASE1);
        check("clkdiv1 toggles", tog, 40);
        check("clkdiv1 start frame data", dbad, 0);
        check("clkdiv1 handshakes", rc, LEDS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end
endmodule
